// File: rtl/fp16_divider.sv
// Multi-cycle IEEE-754 binary16 divider: restoring division, round-to-nearest-even, fixed 17-cycle latency.
// Define FP16_DIV_SUBNORMAL_EN to normalise subnormal operands and produce subnormal results.
module fp16_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out,
  output logic        div_by_zero
);

  localparam int unsigned MANT_W     = 11;
  localparam int unsigned QUO_W      = 14;
  localparam int unsigned EXP_W      = 7;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned DIV_CYCLES = 14;

  typedef enum logic [2:0] {IDLE, UNPACK, NORM, DIV, ROUND, DONE} state_t;

  state_t                    state;
  logic [15:0]               a_r, b_r;
  logic                      sign_r;
  logic signed [EXP_W-1:0]   exp_r;
  logic [MANT_W-1:0]         ma_r, mb_r;
  logic [MANT_W:0]           rem_r;
  logic [QUO_W-1:0]          quo_r;
  logic [CNT_W-1:0]          cnt_r;
  logic                      special_r;
  logic [15:0]               special_val_r;
  logic                      special_dbz_r;

`ifdef FP16_DIV_SUBNORMAL_EN
  function automatic logic [3:0] lzc11(input logic [MANT_W-1:0] m);
    logic [3:0] n;
    logic       found;
    n     = 4'd0;
    found = 1'b0;
    for (int i = MANT_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) found = 1'b1;
        else      n = n + 4'd1;
      end
    end
    return n;
  endfunction
`endif

  // Operand classification, significand extraction and raw exponent difference
  logic [4:0]              ea_c, eb_c, ea_eff_c, eb_eff_c;
  logic [9:0]              fa_c, fb_c;
  logic                    a_zero_c, b_zero_c, a_inf_c, b_inf_c, a_nan_c, b_nan_c;
  logic [MANT_W-1:0]       ma_c, mb_c;
  logic signed [EXP_W-1:0] exp_c;
  logic                    sign_c, special_c, special_dbz_c;
  logic [15:0]             special_val_c;

  always_comb begin
    ea_c          = a_r[14:10];
    eb_c          = b_r[14:10];
    fa_c          = a_r[9:0];
    fb_c          = b_r[9:0];
    sign_c        = a_r[15] ^ b_r[15];
    ea_eff_c      = (ea_c == 5'd0) ? 5'd1 : ea_c;
    eb_eff_c      = (eb_c == 5'd0) ? 5'd1 : eb_c;
    exp_c         = EXP_W'({2'b00, ea_eff_c}) - EXP_W'({2'b00, eb_eff_c}) + EXP_W'(15);
    a_inf_c       = (ea_c == 5'd31) && (fa_c == 10'd0);
    b_inf_c       = (eb_c == 5'd31) && (fb_c == 10'd0);
    a_nan_c       = (ea_c == 5'd31) && (fa_c != 10'd0);
    b_nan_c       = (eb_c == 5'd31) && (fb_c != 10'd0);
`ifdef FP16_DIV_SUBNORMAL_EN
    a_zero_c      = (ea_c == 5'd0) && (fa_c == 10'd0);
    b_zero_c      = (eb_c == 5'd0) && (fb_c == 10'd0);
    ma_c          = {ea_c != 5'd0, fa_c};
    mb_c          = {eb_c != 5'd0, fb_c};
`else
    a_zero_c      = (ea_c == 5'd0);
    b_zero_c      = (eb_c == 5'd0);
    ma_c          = (ea_c != 5'd0) ? {1'b1, fa_c} : '0;
    mb_c          = (eb_c != 5'd0) ? {1'b1, fb_c} : '0;
`endif
    special_c     = 1'b1;
    special_dbz_c = 1'b0;
    special_val_c = 16'h0000;
    if (a_nan_c || b_nan_c || (a_zero_c && b_zero_c) || (a_inf_c && b_inf_c)) begin
      special_val_c = 16'h7E00;
    end else if (b_zero_c) begin
      special_val_c = {sign_c, 15'h7C00};
      special_dbz_c = !a_inf_c;
    end else if (a_inf_c) begin
      special_val_c = {sign_c, 15'h7C00};
    end else if (a_zero_c || b_inf_c) begin
      special_val_c = {sign_c, 15'h0000};
    end else begin
      special_c     = 1'b0;
    end
  end

  // Left-justify subnormal significands so bit 10 is always set before dividing
  logic [MANT_W-1:0]       ma_n_c, mb_n_c;
  logic signed [EXP_W-1:0] exp_n_c;

  always_comb begin
    ma_n_c  = ma_r;
    mb_n_c  = mb_r;
    exp_n_c = exp_r;
`ifdef FP16_DIV_SUBNORMAL_EN
    ma_n_c  = ma_r << lzc11(ma_r);
    mb_n_c  = mb_r << lzc11(mb_r);
    exp_n_c = exp_r - EXP_W'(lzc11(ma_r)) + EXP_W'(lzc11(mb_r));
`endif
  end

  // One restoring-division step: compare, conditionally subtract, shift
  logic                div_ge_c;
  logic [MANT_W-1:0]   rem_sub_c;
  logic [MANT_W:0]     rem_next_c;
  logic [QUO_W-1:0]    quo_next_c;

  always_comb begin
    div_ge_c   = rem_r >= {1'b0, mb_r};
    rem_sub_c  = div_ge_c ? MANT_W'(rem_r - {1'b0, mb_r}) : MANT_W'(rem_r);
    rem_next_c = {rem_sub_c, 1'b0};
    quo_next_c = {quo_r[QUO_W-2:0], div_ge_c};
  end

  // Normalise quotient, round to nearest even, then pack with range handling
  logic [QUO_W-1:0]        q_c;
  logic signed [EXP_W-1:0] e_c;
  logic [MANT_W-1:0]       mant_c;
  logic [MANT_W:0]         sum_c;
  logic                    guard_c, round_c, sticky_c, inc_c;
  logic [15:0]             result_c;
`ifdef FP16_DIV_SUBNORMAL_EN
  logic [EXP_W-1:0]        sh_c;
  logic [MANT_W-1:0]       sub_c;
`endif

  always_comb begin
    q_c = quo_r;
    e_c = exp_r;
    if (!q_c[QUO_W-1]) begin
      q_c = {q_c[QUO_W-2:0], 1'b0};
      e_c = e_c - EXP_W'(1);
    end
    mant_c   = q_c[QUO_W-1:3];
    guard_c  = q_c[2];
    round_c  = q_c[1];
    sticky_c = q_c[0] | (rem_r != '0);
    inc_c    = guard_c & (round_c | sticky_c | mant_c[0]);
    sum_c    = {1'b0, mant_c} + (MANT_W+1)'(inc_c);
    if (sum_c[MANT_W]) begin
      mant_c = sum_c[MANT_W:1];
      e_c    = e_c + EXP_W'(1);
    end else begin
      mant_c = sum_c[MANT_W-1:0];
    end
`ifdef FP16_DIV_SUBNORMAL_EN
    sh_c  = EXP_W'(EXP_W'(1) - e_c);
    sub_c = mant_c >> sh_c;
`endif
    if (special_r) begin
      result_c = special_val_r;
    end else if (e_c >= 7'sd31) begin
      result_c = {sign_r, 15'h7C00};
    end else if (e_c <= 7'sd0) begin
`ifdef FP16_DIV_SUBNORMAL_EN
      result_c = {sign_r, 5'd0, sub_c[9:0]};
`else
      result_c = {sign_r, 15'h0000};
`endif
    end else begin
      result_c = {sign_r, e_c[4:0], mant_c[9:0]};
    end
  end

  // Sequencer and all registered state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      out           <= 16'h0000;
      div_by_zero   <= 1'b0;
      a_r           <= '0;
      b_r           <= '0;
      sign_r        <= 1'b0;
      exp_r         <= '0;
      ma_r          <= '0;
      mb_r          <= '0;
      rem_r         <= '0;
      quo_r         <= '0;
      cnt_r         <= '0;
      special_r     <= 1'b0;
      special_val_r <= '0;
      special_dbz_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_ready && in_valid) begin
            a_r      <= a;
            b_r      <= b;
            in_ready <= 1'b0;
            state    <= UNPACK;
          end else begin
            in_ready <= 1'b1;
          end
        end
        UNPACK: begin
          sign_r        <= sign_c;
          exp_r         <= exp_c;
          ma_r          <= ma_c;
          mb_r          <= mb_c;
          special_r     <= special_c;
          special_val_r <= special_val_c;
          special_dbz_r <= special_dbz_c;
          state         <= NORM;
        end
        NORM: begin
          ma_r  <= ma_n_c;
          mb_r  <= mb_n_c;
          exp_r <= exp_n_c;
          rem_r <= {1'b0, ma_n_c};
          quo_r <= '0;
          cnt_r <= '0;
          state <= DIV;
        end
        DIV: begin
          rem_r <= rem_next_c;
          quo_r <= quo_next_c;
          if (cnt_r == CNT_W'(DIV_CYCLES - 1)) begin
            cnt_r <= '0;
            state <= ROUND;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ROUND: begin
          out         <= result_c;
          div_by_zero <= special_r & special_dbz_r;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
